pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the five-stage integer pipeline. It runs a post-reset bubble-injection sequence and detects load-use hazards. It generates the stall, enable and flush controls for the PC and the IF/ID, ID/EX and EX/MEM registers, and freezes the front end while the multi-cycle multiply/divide unit (MDU) in EX is busy. It also produces the EX-stage operand forwarding selects for the ALU inputs.

## Interface
- FLUSH_CYCLES, 4: cycles of forced bubbles after reset release (1..255)
- MDU_TIMEOUT, 64: maximum MDU_WAIT cycles before an error is flagged (1..65535)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- rs_id, rt_id  in  5 each  source registers of the instruction in ID
- rt_used_id  in  1  ID instruction reads rt
- rs_ex, rt_ex  in  5 each  source registers of the instruction in EX
- rd_ex  in  5  destination of the instruction in EX
- mem_read_ex  in  1  EX instruction is a load
- rd_mem  in  5  destination of the instruction in MEM
- reg_write_mem  in  1  MEM instruction writes the register file
- rd_wb  in  5  destination of the instruction in WB
- reg_write_wb  in  1  WB instruction writes the register file
- branch_taken_ex  in  1  branch resolved taken in EX
- mdu_start_ex  in  1  MDU op entered EX this cycle
- mdu_done  in  1  MDU result valid
- pc_en, if_id_en, id_ex_en  out  1 each  register load enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (zeros)
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 = register file, 01 = MEM, 10 = WB
- state  out  2  00 = INIT, 01 = RUN, 10 = MDU_WAIT
- mdu_err  out  1  sticky MDU timeout flag
- stall_cnt, flush_cnt  out  16 each  performance counters (see Configuration)

## Operation
- The FSM and all counters are registered. Control outputs are combinational from state and inputs.
- **INIT**
  - pc_en = if_id_en = id_ex_en = 0.
  - All three flushes = 1.
  - An 8-bit counter increments each cycle. Transition to RUN when the count reaches FLUSH_CYCLES-1.
- **RUN** default: all enables = 1, all flushes = 0. Priority order within RUN:
  1. mdu_start_ex: pc_en = if_id_en = id_ex_en = 0, ex_mem_flush = 1. Next state is MDU_WAIT and the timeout counter clears. branch_taken_ex is ignored in this cycle.
  2. branch_taken_ex: if_id_flush = id_ex_flush = 1, pc_en = 1 so the PC loads the target.
  3. Load-use: the condition is mem_read_ex & rd_ex≠0 & (rd_ex==rs_id | (rt_used_id & rd_ex==rt_id)). Response: pc_en = if_id_en = 0, id_ex_flush = 1. This is a one-cycle stall.
- **MDU_WAIT**
  - While mdu_done = 0: front end frozen and ex_mem_flush = 1, as in RUN priority 1. The timeout counter increments.
  - When mdu_done = 1: RUN defaults apply in that same cycle, so the result enters MEM. Next state is RUN.
  - If the counter reaches MDU_TIMEOUT-1 with no done: set mdu_err, next state RUN. mdu_err clears only on reset.
- **Forwarding**
  - fwd_a = 01 if reg_write_mem & rd_mem≠0 & rd_mem==rs_ex.
  - Else fwd_a = 10 if reg_write_wb & rd_wb≠0 & rd_wb==rs_ex.
  - Else fwd_a = 00.
  - fwd_b uses the same rules on rt_ex.
  - Forwarding is active in every state. Register 0 never forwards. MEM has priority over WB.

## Timing
- Reset values (reset = 0 sampled at an edge):
  - state = INIT, all counters = 0, mdu_err = 0, stall_cnt = flush_cnt = 0.
  - Outputs are therefore pc_en = if_id_en = id_ex_en = 0 and all flushes = 1.
- After reset is released, INIT lasts exactly FLUSH_CYCLES edges. The first RUN cycle follows.
- Reset asserted mid-operation, including during MDU_WAIT, forces INIT at the next edge. The MDU wait is abandoned.
- Load-use stalls last exactly one cycle, with no state change. A branch flush lasts one cycle.
- mdu_done arriving in the same cycle as mdu_start_ex (RUN) is ignored. Done is sampled only in MDU_WAIT.
- mdu_done in the same cycle as the timeout: done wins, and mdu_err stays unchanged.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cnt increments on each load-use stall cycle and each MDU_WAIT cycle.
  - flush_cnt increments on each branch flush.
  - Both are 16-bit, saturate at 0xFFFF, and clear on reset.
- Not defined: stall_cnt and flush_cnt are tied to 0 and the counter logic is not built.

## Test plan
- Reset low for 3 cycles, FLUSH_CYCLES = 4, then release → state = 00 and all flushes = 1 for 4 cycles; on the 5th cycle state = 01, pc_en = 1, flushes = 0.
- Load in EX with rd_ex = 5, mem_read_ex = 1, rs_id = 5 → exactly one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1; rd_ex = 0 → no stall.
- branch_taken_ex = 1 with a simultaneous load-use → if_id_flush = id_ex_flush = 1, pc_en = 1; flush_cnt increments by 1 with PIPE_CTRL_PERF_EN.
- mdu_start_ex pulse, mdu_done after 10 cycles → front end frozen and ex_mem_flush = 1 for 11 cycles; enables = 1 in the done cycle; state returns to 01.
- MDU_TIMEOUT = 8, no done → mdu_err = 1 after 8 MDU_WAIT cycles, state = 01, mdu_err held until reset.
- rs_ex = 3 with rd_mem = 3 and rd_wb = 3, both writing → fwd_a = 01; drop reg_write_mem → fwd_a = 10; rd_mem = rd_wb = 0 → fwd_a = 00.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, sequencing and forwarding control for the five-stage pipeline (optional PIPE_CTRL_PERF_EN perf counters)
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 4,
    parameter int MDU_TIMEOUT  = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        rt_used_id,
    input  logic [4:0]  rs_ex,
    input  logic [4:0]  rt_ex,
    input  logic [4:0]  rd_ex,
    input  logic        mem_read_ex,
    input  logic [4:0]  rd_mem,
    input  logic        reg_write_mem,
    input  logic [4:0]  rd_wb,
    input  logic        reg_write_wb,
    input  logic        branch_taken_ex,
    input  logic        mdu_start_ex,
    input  logic        mdu_done,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  state,
    output logic        mdu_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    localparam logic [7:0]  INIT_LAST = 8'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TO_LAST   = 16'(MDU_TIMEOUT - 1);

    state_t      cur;
    logic [7:0]  init_cnt;
    logic [15:0] mdu_cnt;
    logic        load_use;

    assign state = cur;

    assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                      ((rd_ex == rs_id) || (rt_used_id && (rd_ex == rt_id)));

    // Pipeline register controls decoded from the current state and hazard inputs
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        case (cur)
            ST_RUN: begin
                if (mdu_start_ex) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_flush = 1'b1;
                end else if (branch_taken_ex) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            ST_WAIT: begin
                // The done cycle runs normally so the MDU result moves into MEM
                if (!mdu_done) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_flush = 1'b1;
                end
            end
            default: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end
        endcase
    end

    // ALU operand forwarding; MEM is newer than WB so it wins, r0 never forwards
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (reg_write_mem && (rd_mem != 5'd0) && (rd_mem == rs_ex))
            fwd_a = 2'b01;
        else if (reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs_ex))
            fwd_a = 2'b10;
        if (reg_write_mem && (rd_mem != 5'd0) && (rd_mem == rt_ex))
            fwd_b = 2'b01;
        else if (reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rt_ex))
            fwd_b = 2'b10;
    end

    // Sequencer: bubble injection after reset, MDU wait with timeout
    always_ff @(posedge clock) begin
        if (!reset) begin
            cur      <= ST_INIT;
            init_cnt <= 8'd0;
            mdu_cnt  <= 16'd0;
            mdu_err  <= 1'b0;
        end else begin
            case (cur)
                ST_INIT: begin
                    if (init_cnt == INIT_LAST)
                        cur <= ST_RUN;
                    else
                        init_cnt <= init_cnt + 8'd1;
                end
                ST_RUN: begin
                    if (mdu_start_ex) begin
                        cur     <= ST_WAIT;
                        mdu_cnt <= 16'd0;
                    end
                end
                ST_WAIT: begin
                    if (mdu_done) begin
                        cur <= ST_RUN;
                    end else if (mdu_cnt == TO_LAST) begin
                        mdu_err <= 1'b1;
                        cur     <= ST_RUN;
                    end else begin
                        mdu_cnt <= mdu_cnt + 16'd1;
                    end
                end
                default: cur <= ST_INIT;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = (cur == ST_WAIT) ||
                       ((cur == ST_RUN) && !mdu_start_ex && !branch_taken_ex && load_use);
    assign flush_evt = (cur == ST_RUN) && !mdu_start_ex && branch_taken_ex;

    // Saturating stall and branch-flush event counters
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (stall_evt && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (flush_evt && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - randomized scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int FLUSH  = 4;
    localparam int TMO    = 8;
    localparam int NCYC   = 3000;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rs_id, rt_id, rs_ex, rt_ex, rd_ex, rd_mem, rd_wb;
    logic        rt_used_id, mem_read_ex, reg_write_mem, reg_write_wb;
    logic        branch_taken_ex, mdu_start_ex, mdu_done;
    logic        pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0]  fwd_a, fwd_b, state;
    logic        mdu_err;
    logic [15:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(.FLUSH_CYCLES(FLUSH), .MDU_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .rs_id(rs_id), .rt_id(rt_id), .rt_used_id(rt_used_id),
        .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
        .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
        .rd_wb(rd_wb), .reg_write_wb(reg_write_wb),
        .branch_taken_ex(branch_taken_ex), .mdu_start_ex(mdu_start_ex), .mdu_done(mdu_done),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .mdu_err(mdu_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    // Reference model: mode 0 = bubbles, 1 = running, 2 = waiting on MDU
    int      m_mode;
    int      init_left;
    int      waited;
    bit      m_err;
    int      m_stalls;
    int      m_flushes;

    logic [44:0] exp_q[$];
    int vectors    = 0;
    int miscompares = 0;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (reg_write_mem && rd_mem != 0 && rd_mem == src) return 2'b01;
        if (reg_write_wb && rd_wb != 0 && rd_wb == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit hazard();
        return mem_read_ex && rd_ex != 0 && (rd_ex == rs_id || (rt_used_id && rd_ex == rt_id));
    endfunction

    // Advance the model across one rising edge using the inputs present at that edge
    task automatic model_step();
        if (!reset) begin
            m_mode = 0; init_left = FLUSH; waited = 0; m_err = 0;
            m_stalls = 0; m_flushes = 0;
        end else if (m_mode == 0) begin
            init_left--;
            if (init_left == 0) m_mode = 1;
        end else if (m_mode == 1) begin
            if (mdu_start_ex) begin
                m_mode = 2; waited = 0;
            end else if (branch_taken_ex) begin
                if (PERF && m_flushes < 65535) m_flushes++;
            end else if (hazard()) begin
                if (PERF && m_stalls < 65535) m_stalls++;
            end
        end else begin
            if (PERF && m_stalls < 65535) m_stalls++;
            if (mdu_done) m_mode = 1;
            else begin
                waited++;
                if (waited == TMO) begin m_err = 1; m_mode = 1; end
            end
        end
    endtask

    function automatic logic [44:0] expected();
        logic [2:0] en, fl;
        logic [1:0] st;
        en = 3'b111; fl = 3'b000;
        if (m_mode == 0) begin
            en = 3'b000; fl = 3'b111;
        end else if (m_mode == 1) begin
            if (mdu_start_ex) begin en = 3'b000; fl = 3'b001; end
            else if (branch_taken_ex) fl = 3'b110;
            else if (hazard()) begin en = 3'b001; fl = 3'b010; end
        end else if (!mdu_done) begin
            en = 3'b000; fl = 3'b001;
        end
        st = (m_mode == 0) ? 2'b00 : (m_mode == 1) ? 2'b01 : 2'b10;
        return {en, fl, fwd_sel(rs_ex), fwd_sel(rt_ex), st, m_err,
                16'(m_stalls), 16'(m_flushes)};
    endfunction

    // Monitor: compare DUT outputs against the oldest queued expectation
    initial begin
        logic [44:0] e, a;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush,
                     fwd_a, fwd_b, state, mdu_err, stall_cnt, flush_cnt};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs vec %0d t=%0t: got %h expected %h (state got %b exp %b)",
                             vectors, $time, a, e, a[34:33], e[34:33]);
                end
            end
        end
    end

    // Driver: random stimulus biased toward register collisions and MDU activity
    initial begin
        reset = 0; rs_id = 0; rt_id = 0; rt_used_id = 0; rs_ex = 0; rt_ex = 0; rd_ex = 0;
        mem_read_ex = 0; rd_mem = 0; reg_write_mem = 0; rd_wb = 0; reg_write_wb = 0;
        branch_taken_ex = 0; mdu_start_ex = 0; mdu_done = 0;
        m_mode = 0; init_left = FLUSH; waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clock);
            model_step();
            #1;
            reset           = (cyc < 3) ? 1'b0 : ($urandom_range(0, 199) != 0);
            rs_id           = 5'($urandom_range(0, 3));
            rt_id           = 5'($urandom_range(0, 3));
            rt_used_id      = 1'($urandom);
            rs_ex           = 5'($urandom_range(0, 3));
            rt_ex           = 5'($urandom_range(0, 3));
            rd_ex           = 5'($urandom_range(0, 3));
            mem_read_ex     = ($urandom_range(0, 2) == 0);
            rd_mem          = 5'($urandom_range(0, 3));
            reg_write_mem   = 1'($urandom);
            rd_wb           = 5'($urandom_range(0, 3));
            reg_write_wb    = 1'($urandom);
            branch_taken_ex = ($urandom_range(0, 7) == 0);
            mdu_start_ex    = ($urandom_range(0, 11) == 0);
            mdu_done        = ($urandom_range(0, 11) == 0);
            exp_q.push_back(expected());
        end
        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
